lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- Responder end of the 4-bit HD44780-style LCD bus that lcd_driver drives: it samples lcd_rs/lcd_w/lcd_e/data, pairs the nibbles, decodes commands and data, and rebuilds the 2x16 display contents.
- Outputs line1/line2 in the same 128-bit ASCII packing used by display blocks (char 0 at [127:120]).
- Used as an on-chip loopback checker and as the bus model in lcd_driver benches.

Parameters:
- MIN_E_HIGH, 2: minimum consecutive clk cycles lcd_e must be high for its falling edge to count as a strobe; shorter pulses are glitches and are ignored (range 1..255).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- lcd_rs  input  1  register select (0 = command, 1 = data).
- lcd_w  input  1  read/write (1 = read).
- lcd_e  input  1  enable strobe; bus is latched on its falling edge.
- data  input  4  bus nibble, high nibble first.
- line1  output  128  row 0 ASCII, DDRAM 0x00-0x0F, char k at [127-8k -: 8].
- line2  output  128  row 1 ASCII, DDRAM 0x40-0x4F, same packing.
- ddram_addr  output  7  current address counter.
- mode_4bit  output  1  1 once 4-bit mode is entered.
- cmd_valid  output  1  one-cycle pulse; cmd_byte is valid.
- cmd_byte  output  8  last decoded command.
- char_valid  output  1  one-cycle pulse; char_byte was written.
- char_byte  output  8  last data byte.
- bus_err  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (async, rst=1): line1 and line2 = all 0x20, ddram_addr=0, I/D=1, mode_4bit=0, state INIT8, all pulses 0, cmd_byte=0, char_byte=0, high-time counter=0.
- Strobe detect:
  - e_q holds registered lcd_e; the high-time counter saturates at 255 while e_q=1.
  - A strobe occurs in the cycle where e_q=1, lcd_e=0 and count>=MIN_E_HIGH.
  - rs/w/data are taken from the registered copies captured while e_q=1.
  - The counter clears on every falling edge.
- Read strobes (w=1): ignored; nibble phase unchanged; no bus_err.
- State machine:
  - INIT8: each strobe is a full 8-bit command {data,4'h0}.
    - Nibble 0x2 with rs=0: mode_4bit<=1, go to HI, cmd_valid pulses with 0x20.
    - Nibble 0x3: cmd pulse 0x30, stay in INIT8.
    - Any other nibble: decoded as a command, stay in INIT8.
  - HI: store nibble and rs, go to LO.
  - LO: byte={hi,lo}.
    - If rs differs from the HI rs: byte dropped, bus_err pulses, go to HI.
    - Otherwise execute the byte, go to HI.
- Command decode (rs=0), priority on the MSB set:
  - 0x01 clear: line1/line2 all 0x20, addr=0, I/D=1.
  - 0x02/0x03 home: addr=0.
  - 0x04-0x07 entry mode: I/D=bit1.
  - 0x80-0xFF: addr=byte[6:0].
  - All other commands: pulse only.
- Data (rs=1): write byte to the cell if addr is in 0x00-0x0F or 0x40-0x4F, else discard. char_valid pulses in both cases. Then step addr.
- Address step:
  - I/D=1: +1, with 0x27->0x40 and 0x67->0x00.
  - I/D=0: -1, with 0x00->0x67 and 0x40->0x27.
  - Other illegal values: +/-1 modulo 128.
- Latency: outputs and pulses update on the clk edge that registers the completing strobe, i.e. the cycle after lcd_e is seen low.
- Mid-operation reset: any partial nibble is lost and the block returns to INIT8.
- Back-to-back strobes: each strobe is handled independently; no strobe is dropped while the MIN_E_HIGH rule is met.

Optional Feature:
- LCD_RX_SYNC_EN defined: a 2-flop synchronizer sits on lcd_rs, lcd_w, lcd_e and data ahead of the strobe logic, for an asynchronous or external bus. All latencies grow by 2 cycles; sync flops reset to 0.
- Not defined: inputs go straight into e_q and the capture registers, for a same-clock source.

Test Plan:
- Init: send nibbles 3,3,3,2 (rs=0) -> cmd pulses 0x30,0x30,0x30,0x20; mode_4bit=1 after the 4th.
- After init, 0x80 then data 'H','i' -> line1[127:112]="Hi", ddram_addr=0x02, two char_valid pulses.
- 0xC0 then data 0x41 x17 -> line2 all 'A', and address 0x50 is discarded. Set address 0x27 then write -> addr becomes 0x40, no visible cell changes.
- Fill cells, then send 0x01 -> both lines all 0x20, addr=0. Send entry 0x04, set 0x85, write 'x' -> line1 cell 5='x', addr=0x04.
- Pulse lcd_e high for 1 cycle with MIN_E_HIGH=2 -> ignored. rs=0 high nibble then rs=1 low nibble -> bus_err pulse, no write, next strobe treated as HI.
- Assert rst after a single HI nibble -> lines all 0x20, mode_4bit=0, state INIT8. A read strobe (w=1) -> no state change.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: responder end of a 4-bit HD44780-style LCD bus.
// Detects qualified lcd_e strobes and pairs nibbles into bytes. It decodes
// commands and data bytes, and rebuilds the 2x16 display contents on
// line1/line2 (char 0 at [127:120]).
// Optional build macro: LCD_RX_SYNC_EN adds a 2-flop input synchronizer
// for a bus that is not driven from clk.
module lcd_bus_receiver #(
    parameter int MIN_E_HIGH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_rs,
    input  logic         lcd_w,
    input  logic         lcd_e,
    input  logic [3:0]   data,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic [6:0]   ddram_addr,
    output logic         mode_4bit,
    output logic         cmd_valid,
    output logic [7:0]   cmd_byte,
    output logic         char_valid,
    output logic [7:0]   char_byte,
    output logic         bus_err
);

    localparam logic [7:0] MIN_E = 8'(MIN_E_HIGH);

    typedef enum logic [1:0] {
        ST_INIT8 = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Bus inputs, optionally synchronized
    // ------------------------------------------------------------------
    logic       rs_in;
    logic       w_in;
    logic       e_in;
    logic [3:0] data_in;

`ifdef LCD_RX_SYNC_EN
    logic [6:0] sync1_reg;
    logic [6:0] sync2_reg;

    // Two-flop synchronizer on the whole bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 7'd0;
            sync2_reg <= 7'd0;
        end else begin
            sync1_reg <= {lcd_rs, lcd_w, lcd_e, data};
            sync2_reg <= sync1_reg;
        end
    end

    assign {rs_in, w_in, e_in, data_in} = sync2_reg;
`else
    assign {rs_in, w_in, e_in, data_in} = {lcd_rs, lcd_w, lcd_e, data};
`endif

    // ------------------------------------------------------------------
    // Strobe detection
    // ------------------------------------------------------------------
    logic       e_q;
    logic [7:0] high_cnt_reg;
    logic       rs_cap_reg;
    logic       w_cap_reg;
    logic [3:0] data_cap_reg;
    logic       strobe;
    logic       wr_strobe;

    // Track enable level and high time; hold the bus sampled while enable is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q          <= 1'b0;
            high_cnt_reg <= 8'd0;
            rs_cap_reg   <= 1'b0;
            w_cap_reg    <= 1'b0;
            data_cap_reg <= 4'd0;
        end else begin
            e_q <= e_in;
            if (e_q && !e_in) begin
                high_cnt_reg <= 8'd0;
            end else if (e_in && (high_cnt_reg != 8'hFF)) begin
                high_cnt_reg <= high_cnt_reg + 8'd1;
            end
            if (e_in) begin
                rs_cap_reg   <= rs_in;
                w_cap_reg    <= w_in;
                data_cap_reg <= data_in;
            end
        end
    end

    // A falling edge counts only after a long enough high phase.
    assign strobe    = e_q && !e_in && (high_cnt_reg >= MIN_E);
    // Read strobes are invisible to the receiver.
    assign wr_strobe = strobe && !w_cap_reg;

    // ------------------------------------------------------------------
    // Nibble-pairing state machine
    // ------------------------------------------------------------------
    state_t     state_reg;
    state_t     state_next;
    logic [3:0] hi_nib_reg;
    logic       hi_rs_reg;
    logic       exec_cmd;
    logic       exec_data;
    logic [7:0] exec_byte;
    logic       proto_err;
    logic       set_4bit;
    logic       store_hi;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT8;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and per-strobe actions.
    always_comb begin
        state_next = state_reg;
        exec_cmd   = 1'b0;
        exec_data  = 1'b0;
        exec_byte  = 8'h00;
        proto_err  = 1'b0;
        set_4bit   = 1'b0;
        store_hi   = 1'b0;
        case (state_reg)
            ST_INIT8: begin
                if (wr_strobe) begin
                    exec_cmd  = 1'b1;
                    exec_byte = {data_cap_reg, 4'h0};
                    if ((data_cap_reg == 4'h2) && !rs_cap_reg) begin
                        set_4bit   = 1'b1;
                        state_next = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (wr_strobe) begin
                    store_hi   = 1'b1;
                    state_next = ST_LO;
                end
            end
            ST_LO: begin
                if (wr_strobe) begin
                    state_next = ST_HI;
                    if (rs_cap_reg != hi_rs_reg) begin
                        proto_err = 1'b1;
                    end else begin
                        exec_byte = {hi_nib_reg, data_cap_reg};
                        exec_cmd  = !rs_cap_reg;
                        exec_data = rs_cap_reg;
                    end
                end
            end
            default: state_next = ST_INIT8;
        endcase
    end

    // ------------------------------------------------------------------
    // Command decode and address counter
    // ------------------------------------------------------------------
    logic [6:0] addr_reg;
    logic [6:0] addr_next;
    logic       id_reg;
    logic       id_next;
    logic       clear_rows;
    logic       wr_row0;
    logic       wr_row1;

    // Address step that skips the unused DDRAM gaps between the two rows.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // Decode the executed byte into address / entry-mode updates.
    always_comb begin
        addr_next  = addr_reg;
        id_next    = id_reg;
        clear_rows = 1'b0;
        if (exec_cmd) begin
            if (exec_byte[7]) begin
                addr_next = exec_byte[6:0];
            end else if (exec_byte[6:3] == 4'd0) begin
                if (exec_byte[2]) begin
                    id_next = exec_byte[1];
                end else if (exec_byte[1]) begin
                    addr_next = 7'h00;
                end else if (exec_byte[0]) begin
                    addr_next  = 7'h00;
                    id_next    = 1'b1;
                    clear_rows = 1'b1;
                end
            end
        end
        if (exec_data) begin
            addr_next = step_addr(addr_reg, id_reg);
        end
    end

    assign wr_row0 = exec_data && (addr_reg[6:4] == 3'b000);
    assign wr_row1 = exec_data && (addr_reg[6:4] == 3'b100);

    // Control registers, nibble holding and output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_nib_reg     <= 4'd0;
            hi_rs_reg      <= 1'b0;
            addr_reg       <= 7'h00;
            id_reg         <= 1'b1;
            mode_4bit      <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_byte       <= 8'h00;
            char_valid     <= 1'b0;
            char_byte      <= 8'h00;
            bus_err        <= 1'b0;
        end else begin
            if (store_hi) begin
                hi_nib_reg <= data_cap_reg;
                hi_rs_reg  <= rs_cap_reg;
            end
            addr_reg   <= addr_next;
            id_reg     <= id_next;
            if (set_4bit) begin
                mode_4bit <= 1'b1;
            end
            cmd_valid  <= exec_cmd;
            char_valid <= exec_data;
            bus_err    <= proto_err;
            if (exec_cmd) begin
                cmd_byte <= exec_byte;
            end
            if (exec_data) begin
                char_byte <= exec_byte;
            end
        end
    end

    assign ddram_addr = addr_reg;

    // ------------------------------------------------------------------
    // Display cells: 16 per row, packed char 0 first
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 16; gi++) begin : g_cell
        logic [7:0] row0_reg;
        logic [7:0] row1_reg;

        // One cell per row; cleared to space, written when the address hits it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                row0_reg <= 8'h20;
                row1_reg <= 8'h20;
            end else if (clear_rows) begin
                row0_reg <= 8'h20;
                row1_reg <= 8'h20;
            end else begin
                if (wr_row0 && (addr_reg[3:0] == 4'(gi))) begin
                    row0_reg <= exec_byte;
                end
                if (wr_row1 && (addr_reg[3:0] == 4'(gi))) begin
                    row1_reg <= exec_byte;
                end
            end
        end

        assign line1[127-8*gi -: 8] = row0_reg;
        assign line2[127-8*gi -: 8] = row1_reg;
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives the 4-bit bus the way the
// driver does and checks decoded pulses, address counter and rebuilt rows.
module tb_lcd_bus_receiver;

    logic         clk;
    logic         rst;
    logic         lcd_rs;
    logic         lcd_w;
    logic         lcd_e;
    logic [3:0]   data;
    logic [127:0] line1;
    logic [127:0] line2;
    logic [6:0]   ddram_addr;
    logic         mode_4bit;
    logic         cmd_valid;
    logic [7:0]   cmd_byte;
    logic         char_valid;
    logic [7:0]   char_byte;
    logic         bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cmd_cnt  = 0;
    int char_cnt = 0;
    int err_cnt  = 0;
    logic [7:0] last_cmd = 8'h00;

    localparam logic [127:0] SPACES = {16{8'h20}};

    lcd_bus_receiver #(.MIN_E_HIGH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_rs     (lcd_rs),
        .lcd_w      (lcd_w),
        .lcd_e      (lcd_e),
        .data       (data),
        .line1      (line1),
        .line2      (line2),
        .ddram_addr (ddram_addr),
        .mode_4bit  (mode_4bit),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .char_valid (char_valid),
        .char_byte  (char_byte),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_cnt  <= cmd_cnt + 1;
            last_cmd <= cmd_byte;
        end
        if (char_valid) char_cnt <= char_cnt + 1;
        if (bus_err)    err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // One enable pulse of high_cycles clocks carrying one nibble.
    task automatic strobe(input logic rs_i, input logic [3:0] nib, input logic w_i,
                          input int high_cycles);
        @(posedge clk); #1;
        lcd_rs = rs_i;
        lcd_w  = w_i;
        data   = nib;
        lcd_e  = 1'b1;
        repeat (high_cycles) @(posedge clk);
        #1;
        lcd_e = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic rs_i, input logic [7:0] b);
        strobe(rs_i, b[7:4], 1'b0, 2);
        strobe(rs_i, b[3:0], 1'b0, 2);
    endtask

    initial begin
        int c0;
        int ch0;
        rst    = 1'b1;
        lcd_rs = 1'b0;
        lcd_w  = 1'b0;
        lcd_e  = 1'b0;
        data   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_line1", line1, SPACES);
        chk("rst_line2", line2, SPACES);
        chk("rst_addr", 128'(ddram_addr), 128'(7'h00));
        chk("rst_mode", 128'(mode_4bit), 128'(1'b0));
        chk("rst_pulses", 128'({cmd_valid, char_valid, bus_err}), 128'(3'b000));
        chk("rst_bytes", 128'({cmd_byte, char_byte}), 128'(16'h0000));
        rst = 1'b0;
        @(posedge clk); #1;

        // Init sequence in 8-bit mode.
        strobe(1'b0, 4'h3, 1'b0, 2);
        strobe(1'b0, 4'h3, 1'b0, 2);
        strobe(1'b0, 4'h3, 1'b0, 2);
        chk("init_30_cnt", 128'(cmd_cnt), 128'(3));
        chk("init_30_byte", 128'(last_cmd), 128'(8'h30));
        chk("init_mode_still0", 128'(mode_4bit), 128'(1'b0));
        strobe(1'b0, 4'h2, 1'b0, 2);
        chk("init_20_byte", 128'(last_cmd), 128'(8'h20));
        chk("init_mode4", 128'(mode_4bit), 128'(1'b1));
        chk("init_cnt4", 128'(cmd_cnt), 128'(4));

        // Write "Hi" at the start of row 0.
        send_byte(1'b0, 8'h80);
        chk("set80_cmd", 128'(last_cmd), 128'(8'h80));
        send_byte(1'b1, 8'h48);
        send_byte(1'b1, 8'h69);
        chk("hi_line1", line1, {8'h48, 8'h69, {14{8'h20}}});
        chk("hi_addr", 128'(ddram_addr), 128'(7'h02));
        chk("hi_chars", 128'(char_cnt), 128'(2));
        chk("hi_char_byte", 128'(char_byte), 128'(8'h69));

        // 17 'A' into row 1: the 17th lands on 0x50 and is discarded.
        send_byte(1'b0, 8'hC0);
        chk("setC0_addr", 128'(ddram_addr), 128'(7'h40));
        for (int i = 0; i < 17; i++) send_byte(1'b1, 8'h41);
        chk("rowA_line2", line2, {16{8'h41}});
        chk("rowA_line1", line1, {8'h48, 8'h69, {14{8'h20}}});
        chk("rowA_addr", 128'(ddram_addr), 128'(7'h51));

        // 0x27 -> 0x40 wrap, write not visible.
        send_byte(1'b0, 8'hA7);
        ch0 = char_cnt;
        send_byte(1'b1, 8'h5A);
        chk("wrap27_addr", 128'(ddram_addr), 128'(7'h40));
        chk("wrap27_lines", {line1[127:64], line2[63:0]},
            {8'h48, 8'h69, {6{8'h20}}, {8{8'h41}}});
        chk("wrap27_char", 128'(char_cnt - ch0), 128'(1));

        // Clear display.
        send_byte(1'b0, 8'h01);
        chk("clr_line1", line1, SPACES);
        chk("clr_line2", line2, SPACES);
        chk("clr_addr", 128'(ddram_addr), 128'(7'h00));

        // Decrement mode and its wraps.
        send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'h85);
        send_byte(1'b1, 8'h78);
        chk("dec_line1", line1, {{5{8'h20}}, 8'h78, {10{8'h20}}});
        chk("dec_addr", 128'(ddram_addr), 128'(7'h04));
        send_byte(1'b0, 8'hC0);
        send_byte(1'b1, 8'h79);
        chk("dec40_addr", 128'(ddram_addr), 128'(7'h27));
        chk("dec40_line2", line2, {8'h79, {15{8'h20}}});
        send_byte(1'b0, 8'h80);
        send_byte(1'b1, 8'h7A);
        chk("dec00_addr", 128'(ddram_addr), 128'(7'h67));
        chk("dec00_line1", line1, {8'h7A, {4{8'h20}}, 8'h78, {10{8'h20}}});

        // Back to increment; 0x67 -> 0x00.
        send_byte(1'b0, 8'h06);
        send_byte(1'b0, 8'hE7);
        send_byte(1'b1, 8'h21);
        chk("inc67_addr", 128'(ddram_addr), 128'(7'h00));
        send_byte(1'b0, 8'h02);
        chk("home_cmd", 128'(last_cmd), 128'(8'h02));

        // Short enable pulse must be ignored.
        c0 = cmd_cnt;
        strobe(1'b0, 4'h8, 1'b0, 1);
        chk("glitch_nocmd", 128'(cmd_cnt - c0), 128'(0));

        // rs mismatch between nibbles.
        ch0 = char_cnt;
        strobe(1'b0, 4'h4, 1'b0, 2);
        strobe(1'b1, 4'h1, 1'b0, 2);
        chk("rserr_buserr", 128'(err_cnt), 128'(1));
        chk("rserr_nochar", 128'(char_cnt - ch0), 128'(0));
        chk("rserr_line1", line1, {8'h7A, {4{8'h20}}, 8'h78, {10{8'h20}}});
        send_byte(1'b0, 8'h81);
        chk("rserr_resync", 128'(ddram_addr), 128'(7'h01));

        // Read strobe: no effect, phase kept.
        c0 = cmd_cnt;
        strobe(1'b0, 4'h8, 1'b1, 2);
        chk("read_nocmd", 128'(cmd_cnt - c0), 128'(0));
        send_byte(1'b0, 8'hC3);
        chk("read_phase", 128'(ddram_addr), 128'(7'h43));
        chk("read_noerr", 128'(err_cnt), 128'(1));

        // Reset after a lone high nibble.
        strobe(1'b1, 4'h4, 1'b0, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_line1", line1, SPACES);
        chk("mrst_mode", 128'(mode_4bit), 128'(1'b0));
        chk("mrst_addr", 128'(ddram_addr), 128'(7'h00));
        rst = 1'b0;
        @(posedge clk); #1;
        c0 = cmd_cnt;
        strobe(1'b0, 4'h8, 1'b0, 2);
        chk("mrst_init8_cmd", 128'(last_cmd), 128'(8'h80));
        chk("mrst_init8_cnt", 128'(cmd_cnt - c0), 128'(1));
        chk("mrst_init8_mode", 128'(mode_4bit), 128'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
